// File: rtl/instr_prefetch_unit_pkg.sv
// rtl/instr_prefetch_unit_pkg.sv - shared types and constants for the instruction prefetch unit
package instr_prefetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/instr_prefetch_unit_fetch_fifo.sv
// rtl/instr_prefetch_unit_fetch_fifo.sv - synchronous {pc, instr} FIFO with clear over push/pop
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(push_i) - CW'(pop_i);
        end
    end

    // The caller only pushes into a full FIFO together with a pop.
    always @(posedge clk_i) begin
        if (!rst_i && !clear_i) begin
            assert (!(push_i && full_o && !pop_i));
            assert (!(pop_i && empty_o));
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/instr_prefetch_unit.sv
// rtl/instr_prefetch_unit.sv - sequential instruction prefetcher with branch redirect and wrong-path discard
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    input  logic               instr_ready_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INSTR_W-1:0] mem_rdata_i
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_hold_addr;
    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [63:0]         w_head;

    assign w_pop  = !w_empty && instr_ready_i && !redirect_i;
    assign w_push = (r_state == ST_FETCH) && w_req && mem_ack_i && !redirect_i;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                // A pop frees a slot this cycle, so a full FIFO may still request.
                w_req = !w_full || (!w_empty && instr_ready_i);
                if (redirect_i && w_req && !mem_ack_i) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                w_req = 1'b1;
                if (mem_ack_i) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_hold_addr <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            // The stale request keeps its address until the memory acks it.
            if (r_state == ST_FETCH && redirect_i && w_req && !mem_ack_i) begin
                r_hold_addr <= r_fetch_pc;
            end
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (w_count <= CW'(DEPTH));
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fetch_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (redirect_i),
        .push_i  (w_push),
        .data_i  ({r_fetch_pc, mem_rdata_i}),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign mem_req_o     = w_req;
    assign mem_addr_o    = (r_state == ST_DISCARD) ? r_hold_addr : r_fetch_pc;
    assign instr_valid_o = !w_empty;
    assign instr_o       = instr_valid_o ? w_head[31:0] : '0;
    assign pc_o          = instr_valid_o ? w_head[63:32] : '0;
    assign pc_plus4_o    = instr_valid_o ? (w_head[63:32] + 32'd4) : '0;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb/tb_instr_prefetch_unit.sv - directed self-checking bench for instr_prefetch_unit
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready = 1'b1;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int wait_cyc = 0;
    int wcnt;
    logic mon_en = 1'b0;
    logic saw40  = 1'b0;

    instr_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_ready_i (ready),
        .instr_valid_o (valid),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus4_o    (pc4),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: acks after wait_cyc stall cycles, data derived from address.
    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign mem_ack   = mem_req && (wcnt >= wait_cyc);
    assign mem_rdata = mem_addr ^ 32'hC0DE_0000;

    always @(negedge clk) begin
        if (mon_en && valid && pc == 32'h40) saw40 <= 1'b1;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy, input int w);
        rst      = 1'b1;
        redirect = 1'b0;
        ready    = rdy;
        wait_cyc = w;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset values, zero-wait streaming
        ready = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pc4", pc4, 32'h0);
        do_reset(1'b1, 0);
        check_eq("t1_idle_req", 32'(mem_req), 32'd0);
        tick();
        check_eq("t1_req", 32'(mem_req), 32'd1);
        check_eq("t1_addr0", mem_addr, 32'h0);
        check_eq("t1_valid_c1", 32'(valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("t1_valid", 32'(valid), 32'd1);
            check_eq("t1_pc", pc, 32'(k * 4));
            check_eq("t1_pc4", pc4, 32'(k * 4 + 4));
            check_eq("t1_instr", instr, word_of(32'(k * 4)));
            check_eq("t1_addr", mem_addr, 32'(k * 4 + 4));
            tick();
        end

        // 2: three-cycle memory
        do_reset(1'b1, 2);
        tick();
        check_eq("t2_addr_a", mem_addr, 32'h0);
        check_eq("t2_ack_a", 32'(mem_ack), 32'd0);
        tick();
        check_eq("t2_addr_b", mem_addr, 32'h0);
        check_eq("t2_ack_b", 32'(mem_ack), 32'd0);
        tick();
        check_eq("t2_addr_c", mem_addr, 32'h0);
        check_eq("t2_ack_c", 32'(mem_ack), 32'd1);
        tick();
        check_eq("t2_valid0", 32'(valid), 32'd1);
        check_eq("t2_pc0", pc, 32'h0);
        check_eq("t2_addr4", mem_addr, 32'h4);
        tick();
        check_eq("t2_gap", 32'(valid), 32'd0);
        tick();
        tick();
        check_eq("t2_valid4", 32'(valid), 32'd1);
        check_eq("t2_pc4", pc, 32'h4);

        // 3: stall fills FIFO, then drain
        do_reset(1'b0, 0);
        for (int k = 0; k < 10; k++) tick();
        check_eq("t3_full_req", 32'(mem_req), 32'd0);
        check_eq("t3_head", pc, 32'h0);
        check_eq("t3_addr", mem_addr, 32'h10);
        ready = 1'b1;
        #1;
        check_eq("t3_resume_req", 32'(mem_req), 32'd1);
        check_eq("t3_resume_addr", mem_addr, 32'h10);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("t3_drain_pc", pc, 32'(k * 4));
            check_eq("t3_drain_instr", instr, word_of(32'(k * 4)));
        end

        // 4: redirect coincident with ack, FIFO holding 3
        do_reset(1'b0, 0);
        for (int k = 0; k < 4; k++) tick();
        check_eq("t4_head", pc, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t4_valid_drop", 32'(valid), 32'd0);
        check_eq("t4_req", 32'(mem_req), 32'd1);
        check_eq("t4_addr", mem_addr, 32'h100);
        tick();
        check_eq("t4_valid", 32'(valid), 32'd1);
        check_eq("t4_pc", pc, 32'h100);
        check_eq("t4_instr", instr, word_of(32'h100));

        // 5: redirect while a slow request is pending
        do_reset(1'b0, 0);
        for (int k = 0; k < 5; k++) tick();
        check_eq("t5_full_noreq", 32'(mem_req), 32'd0);
        wait_cyc = 3;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t5_req40", 32'(mem_req), 32'd1);
        check_eq("t5_addr40", mem_addr, 32'h40);
        check_eq("t5_empty", 32'(valid), 32'd0);
        mon_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t5_hold_a", mem_addr, 32'h40);
        check_eq("t5_hold_req", 32'(mem_req), 32'd1);
        tick();
        check_eq("t5_hold_b", mem_addr, 32'h40);
        tick();
        check_eq("t5_hold_c", mem_addr, 32'h40);
        check_eq("t5_ack40", 32'(mem_ack), 32'd1);
        tick();
        check_eq("t5_addr200", mem_addr, 32'h200);
        check_eq("t5_dropped", 32'(valid), 32'd0);
        begin
            int n = 0;
            while (!valid && n < 20) begin
                tick();
                n++;
            end
            check_eq("t5_valid_timeout", 32'(valid), 32'd1);
        end
        check_eq("t5_pc200", pc, 32'h200);
        mon_en = 1'b0;
        check_eq("t5_no40", 32'(saw40), 32'd0);

        // 6: redirect + ack + pop on full FIFO, then async reset mid-request
        do_reset(1'b0, 0);
        for (int k = 0; k < 5; k++) tick();
        ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h300;
        #1;
        check_eq("t6_ack", 32'(mem_ack), 32'd1);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t6_cleared", 32'(valid), 32'd0);
        check_eq("t6_addr", mem_addr, 32'h300);
        tick();
        check_eq("t6_pc300", pc, 32'h300);
        wait_cyc = 5;
        ready = 1'b0;
        #1;
        check_eq("t6_pending", 32'(mem_req & ~mem_ack), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 32'(valid), 32'd0);
        check_eq("t6_rst_req", 32'(mem_req), 32'd0);
        check_eq("t6_rst_addr", mem_addr, 32'h0);
        check_eq("t6_rst_pc", pc, 32'h0);
        check_eq("t6_rst_instr", instr, 32'h0);
        @(negedge clk);
        wait_cyc = 0;
        ready = 1'b1;
        rst = 1'b0;
        tick();
        check_eq("t6_restart_req", 32'(mem_req), 32'd1);
        check_eq("t6_restart_addr", mem_addr, 32'h0);
        tick();
        check_eq("t6_restart_pc", pc, 32'h0);
        check_eq("t6_restart_valid", 32'(valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
